// File: rtl/rx_mac_if.sv
//------------------------------------------------------------------------------
// Module : rgmii_rx_if / axis_rx_if
// Brief  : RGMII receive byte bus and receive AXI-Stream bus for rx_mac.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface rgmii_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] rgmii_mac_rx_data;
    logic                  rgmii_mac_rx_dv;
    logic                  rgmii_mac_rx_er;

    modport master (
        output rgmii_mac_rx_data,
        output rgmii_mac_rx_dv,
        output rgmii_mac_rx_er
    );
    modport slave (
        input  rgmii_mac_rx_data,
        input  rgmii_mac_rx_dv,
        input  rgmii_mac_rx_er
    );
endinterface

interface axis_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] m_rx_axis_tdata;
    logic                  m_rx_axis_tvalid;
    logic                  m_rx_axis_tlast;
    logic                  m_rx_axis_tuser;

    modport master (
        output m_rx_axis_tdata,
        output m_rx_axis_tvalid,
        output m_rx_axis_tlast,
        output m_rx_axis_tuser
    );
    modport slave (
        input  m_rx_axis_tdata,
        input  m_rx_axis_tvalid,
        input  m_rx_axis_tlast,
        input  m_rx_axis_tuser
    );
endinterface

`default_nettype wire

// File: rtl/rx_mac.sv
//------------------------------------------------------------------------------
// Module : rx_mac
// Brief  : Receive Ethernet MAC: SFD detect, FCS strip, CRC/length/er check,
//          AXI-Stream output. Optional CRC check: define RX_MAC_CRC_CHECK_EN.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module rx_mac #(
    parameter int DATA_WIDTH = 8,
    parameter int MIN_FRAME  = 64,
    parameter int MAX_FRAME  = 1518
) (
    input  wire        clk,
    input  wire        reset_n,
    rgmii_rx_if.slave  i_rgmii,
    axis_rx_if.master  o_rx_axis
);

    localparam logic [7:0]  c_PRE_BYTE = 8'h55;
    localparam logic [7:0]  c_SFD_BYTE = 8'hD5;
    localparam logic [10:0] c_MIN_LEN  = 11'(MIN_FRAME);
    localparam logic [10:0] c_MAX_LEN  = 11'(MAX_FRAME);
    localparam logic [10:0] c_LEN_SAT  = 11'h7FF;
    localparam logic [2:0]  c_DLY_FULL = 3'd5;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        PREAMBLE  = 2'd2,
        DATA      = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_start;
    logic                  w_push;
    logic                  w_final;
    logic                  w_bad;

    logic [DATA_WIDTH-1:0] r_dly [0:4];
    logic [2:0]            r_cnt;
    logic [10:0]           r_len;
    logic                  r_err;

    logic                  r_tvalid;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic                  r_tlast;
    logic                  r_tuser;

    logic [7:0]            w_byte;
    logic                  w_dv;
    logic                  w_er;

    assign w_byte = 8'(i_rgmii.rgmii_mac_rx_data);
    assign w_dv   = i_rgmii.rgmii_mac_rx_dv;
    assign w_er   = i_rgmii.rgmii_mac_rx_er;

`ifdef RX_MAC_CRC_CHECK_EN
    localparam logic [31:0] c_POLY    = 32'hEDB88320;
    localparam logic [31:0] c_RESIDUE = 32'hDEBB20E3;

    logic [31:0] r_crc;
    logic [31:0] w_crc_nxt;

    always_comb begin
        w_crc_nxt = r_crc ^ {24'd0, w_byte};
        for (int b = 0; b < 8; b++) begin
            w_crc_nxt = w_crc_nxt[0] ? ((w_crc_nxt >> 1) ^ c_POLY) : (w_crc_nxt >> 1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_crc <= 32'hFFFFFFFF;
        end else if (w_start) begin
            r_crc <= 32'hFFFFFFFF;
        end else if (w_push) begin
            r_crc <= w_crc_nxt;
        end
    end

    assign w_bad = r_err || (r_len < c_MIN_LEN) || (r_len > c_MAX_LEN) || (r_crc != c_RESIDUE);
`else
    assign w_bad = r_err || (r_len < c_MIN_LEN) || (r_len > c_MAX_LEN);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= WAIT_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_push      = 1'b0;
        w_final     = 1'b0;
        case (r_state)
            WAIT_IDLE: begin
                if (!w_dv) w_state_nxt = IDLE;
            end
            IDLE: begin
                if (w_dv) begin
                    w_state_nxt = (!w_er && w_byte == c_PRE_BYTE) ? PREAMBLE : WAIT_IDLE;
                end
            end
            PREAMBLE: begin
                if (w_dv && !w_er && w_byte == c_PRE_BYTE) begin
                    w_state_nxt = PREAMBLE;
                end else if (w_dv && !w_er && w_byte == c_SFD_BYTE) begin
                    w_state_nxt = DATA;
                    w_start     = 1'b1;
                end else begin
                    w_state_nxt = WAIT_IDLE;
                end
            end
            DATA: begin
                if (w_dv) begin
                    w_push = 1'b1;
                end else begin
                    w_final     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = WAIT_IDLE;
        endcase
    end

    // Newest byte enters r_dly[0]; once five are held, r_dly[4] is payload
    // and the four younger bytes are the candidate FCS.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 5; i++) r_dly[i] <= '0;
            r_cnt    <= 3'd0;
            r_len    <= 11'd0;
            r_err    <= 1'b0;
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tlast  <= 1'b0;
            r_tuser  <= 1'b0;
        end else begin
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tlast  <= 1'b0;
            r_tuser  <= 1'b0;
            if (w_start) begin
                r_cnt <= 3'd0;
                r_len <= 11'd0;
                r_err <= 1'b0;
            end
            if (w_push) begin
                r_dly[0] <= DATA_WIDTH'(w_byte);
                for (int i = 1; i < 5; i++) r_dly[i] <= r_dly[i-1];
                if (r_cnt != c_DLY_FULL) r_cnt <= r_cnt + 3'd1;
                if (r_len != c_LEN_SAT)  r_len <= r_len + 11'd1;
                if (w_er) r_err <= 1'b1;
                if (r_cnt == c_DLY_FULL) begin
                    r_tvalid <= 1'b1;
                    r_tdata  <= r_dly[4];
                end
            end
            if (w_final) begin
                r_cnt <= 3'd0;
                if (r_cnt == c_DLY_FULL) begin
                    r_tvalid <= 1'b1;
                    r_tdata  <= r_dly[4];
                    r_tlast  <= 1'b1;
                    r_tuser  <= w_bad;
                end
            end
        end
    end

    assign o_rx_axis.m_rx_axis_tvalid = r_tvalid;
    assign o_rx_axis.m_rx_axis_tdata  = r_tdata;
    assign o_rx_axis.m_rx_axis_tlast  = r_tlast;
    assign o_rx_axis.m_rx_axis_tuser  = r_tuser;

endmodule

`default_nettype wire

// File: tb/tb_rx_mac.sv
//------------------------------------------------------------------------------
// Module : tb_rx_mac
// Brief  : Directed + randomized frames for rx_mac, checked against a frame-level reference model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_rx_mac;

    localparam int MIN_FRAME = 64;
    localparam int MAX_FRAME = 1518;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    logic       clk;
    logic       reset_n;
    int         cyc;
    int         n_vec;
    int         n_err;
    beat_t      exp_q[$];
    logic [7:0] fr[$];

    rgmii_rx_if #(.DATA_WIDTH(8)) rx_if ();
    axis_rx_if  #(.DATA_WIDTH(8)) ax_if ();

    rx_mac #(
        .DATA_WIDTH (8),
        .MIN_FRAME  (MIN_FRAME),
        .MAX_FRAME  (MAX_FRAME)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_rgmii   (rx_if),
        .o_rx_axis (ax_if)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL timeout: run did not finish, vectors=%0d miscompares=%0d", n_vec, n_err);
        $fatal(1, "timeout");
    end

    // Reference CRC-32 over fr[0..n-1], serial LSB-first, returns the FCS value.
    function automatic logic [31:0] crc_of(input int n);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ fr[i][b];
                c  = {1'b0, c[31:1]};
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    task automatic drive(input logic dv, input logic er, input logic [7:0] d);
        @(negedge clk);
        rx_if.rgmii_mac_rx_dv   = dv;
        rx_if.rgmii_mac_rx_er   = er;
        rx_if.rgmii_mac_rx_data = d;
    endtask

    task automatic push_beat(input logic [7:0] d, input logic last, input logic user);
        beat_t e;
        e.cyc  = cyc + 1;
        e.data = d;
        e.last = last;
        e.user = user;
        exp_q.push_back(e);
    endtask

    task automatic build_frame(input int plen, input bit rnd, input bit corrupt);
        logic [31:0] c;
        fr.delete();
        for (int i = 0; i < plen; i++) fr.push_back(rnd ? 8'($urandom) : 8'(i));
        c = crc_of(plen);
        fr.push_back(c[7:0]);
        fr.push_back(c[15:8]);
        fr.push_back(c[23:16]);
        fr.push_back(c[31:24]);
        if (corrupt) fr[plen] = fr[plen] ^ 8'h01;
    endtask

    // Sends preamble, SFD, fr[] (payload+FCS), then one dv=0 plus 'gap' idles.
    task automatic send_frame(input int npre, input int er_idx, input int gap);
        int   n;
        logic bad;
        n   = fr.size();
        bad = (er_idx >= 0 && er_idx < n) || (n < MIN_FRAME) || (n > MAX_FRAME);
`ifdef RX_MAC_CRC_CHECK_EN
        if (n >= 4) begin
            if (crc_of(n - 4) != {fr[n-1], fr[n-2], fr[n-3], fr[n-4]}) bad = 1'b1;
        end
`endif
        for (int i = 0; i < npre; i++) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int k = 0; k < n; k++) begin
            drive(1'b1, (k == er_idx), fr[k]);
            if (k >= 5) push_beat(fr[k-5], 1'b0, 1'b0);
        end
        drive(1'b0, 1'b0, 8'h00);
        if (n >= 5) push_beat(fr[n-5], 1'b1, bad);
        for (int i = 0; i < gap; i++) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic check_outputs_zero(input string tag);
        n_vec++;
        assert ({ax_if.m_rx_axis_tvalid, ax_if.m_rx_axis_tdata,
                 ax_if.m_rx_axis_tlast, ax_if.m_rx_axis_tuser} === 11'd0)
        else begin
            n_err++;
            $error("FAIL %s: outputs=%h want 000", tag,
                   {ax_if.m_rx_axis_tvalid, ax_if.m_rx_axis_tdata,
                    ax_if.m_rx_axis_tlast, ax_if.m_rx_axis_tuser});
        end
    endtask

    // Scoreboard: every beat must match the next expected beat and its cycle.
    always @(negedge clk) begin
        beat_t e;
        int    due;
        if (ax_if.m_rx_axis_tvalid === 1'b1) begin
            n_vec++;
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else e = '{cyc: -1, data: 8'h00, last: 1'b0, user: 1'b0};
            assert (cyc === e.cyc && ax_if.m_rx_axis_tdata === e.data &&
                    ax_if.m_rx_axis_tlast === e.last && ax_if.m_rx_axis_tuser === e.user)
            else begin
                n_err++;
                $error("FAIL beat: got cyc=%0d data=%h last=%b user=%b, want cyc=%0d data=%h last=%b user=%b",
                       cyc, ax_if.m_rx_axis_tdata, ax_if.m_rx_axis_tlast, ax_if.m_rx_axis_tuser,
                       e.cyc, e.data, e.last, e.user);
            end
        end else begin
            due = (exp_q.size() != 0) ? exp_q[0].cyc : 32'h7FFFFFFF;
            n_vec++;
            assert (ax_if.m_rx_axis_tvalid === 1'b0 && ax_if.m_rx_axis_tdata === 8'h00 &&
                    ax_if.m_rx_axis_tlast === 1'b0 && ax_if.m_rx_axis_tuser === 1'b0 && due > cyc)
            else begin
                n_err++;
                $error("FAIL idle: got valid=%b data=%h last=%b user=%b at cyc=%0d, want zeros and next beat due %0d later",
                       ax_if.m_rx_axis_tvalid, ax_if.m_rx_axis_tdata, ax_if.m_rx_axis_tlast,
                       ax_if.m_rx_axis_tuser, cyc, due);
                if (due <= cyc) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        n_vec   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        rx_if.rgmii_mac_rx_dv   = 1'b0;
        rx_if.rgmii_mac_rx_er   = 1'b0;
        rx_if.rgmii_mac_rx_data = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        #1 check_outputs_zero("reset_state");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) drive(1'b0, 1'b0, 8'h00);

        // Good 64-byte frame, then the same frame with a flipped FCS bit
        build_frame(60, 1'b0, 1'b0);
        send_frame(7, -1, 3);
        build_frame(60, 1'b0, 1'b1);
        send_frame(7, -1, 3);

        // PHY error on byte 10
        build_frame(60, 1'b0, 1'b0);
        send_frame(7, 10, 3);

        // Runt with one-byte preamble, then a 3-byte frame that yields nothing
        build_frame(20, 1'b1, 1'b0);
        send_frame(1, -1, 3);
        fr.delete();
        fr.push_back(8'hA1); fr.push_back(8'hB2); fr.push_back(8'hC3);
        send_frame(7, -1, 3);

        // Broken preamble followed by a body without a dv gap: no beats
        build_frame(60, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'h57);
        drive(1'b1, 1'b0, 8'hD5);
        for (int k = 0; k < fr.size(); k++) drive(1'b1, 1'b0, fr[k]);
        drive(1'b0, 1'b0, 8'h00);
        send_frame(7, -1, 3);

        // Length boundaries: 63 runt, 64 ok, 1518 ok, 1519 giant
        build_frame(59, 1'b1, 1'b0);   send_frame(7, -1, 2);
        build_frame(60, 1'b1, 1'b0);   send_frame(7, -1, 2);
        build_frame(1514, 1'b1, 1'b0); send_frame(7, -1, 2);
        build_frame(1515, 1'b1, 1'b0); send_frame(7, -1, 2);

        // Randomized frames
        for (int f = 0; f < 20; f++) begin
            int plen;
            int eidx;
            plen = int'($urandom_range(40, 130));
            eidx = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, plen + 3)) : -1;
            build_frame(plen, 1'b1, ($urandom_range(0, 3) == 0));
            send_frame(int'($urandom_range(1, 7)), eidx, int'($urandom_range(0, 3)));
        end

        // Two back-to-back good frames, then a third frame abandoned by reset
        build_frame(60, 1'b1, 1'b0); send_frame(7, -1, 0);
        build_frame(70, 1'b1, 1'b0); send_frame(7, -1, 0);
        build_frame(60, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int k = 0; k < 30; k++) begin
            drive(1'b1, 1'b0, fr[k]);
            if (k >= 5) push_beat(fr[k-5], 1'b0, 1'b0);
        end
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        exp_q.delete();
        for (int k = 30; k < 34; k++) begin
            drive(1'b1, 1'b0, fr[k]);
            #1 check_outputs_zero("mid_frame_reset");
        end
        // Released while dv is high: a full preamble+SFD must be ignored
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int k = 0; k < 20; k++) drive(1'b1, 1'b0, 8'($urandom));
        drive(1'b0, 1'b0, 8'h00);
        build_frame(60, 1'b1, 1'b0);
        send_frame(7, -1, 8);

        n_vec++;
        assert (exp_q.size() === 0)
        else begin
            n_err++;
            $error("FAIL drain: %0d expected beats never seen, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
